// File: rtl/unidad_acceso_memoria_if.sv
// -----------------------------------------------------------------------------
// unidad_acceso_memoria_if
// Data-memory bus between the load/store unit (master) and memory (slave).
//   mem_req   : request, held high until acknowledge or abort
//   mem_we    : write strobe (1 = store)
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables, one per lane
//   mem_wdata : lane-aligned store data
//   mem_ack   : acknowledge; mem_rdata is valid in the same cycle for loads
//   mem_rdata : read data
// -----------------------------------------------------------------------------
interface unidad_acceso_memoria_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/unidad_acceso_memoria.sv
// -----------------------------------------------------------------------------
// unidad_acceso_memoria
// Load/store access unit: turns one execute-stage request into a single
// word-aligned bus transaction with byte enables and a timeout, and returns
// the sign/zero-extended load result to the write-back selector.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   inicio          : start pulse, accepted only when idle
//   escritura       : 1 = store, 0 = load (sampled with inicio)
//   funct3          : RV32I width/sign code (sampled with inicio)
//   direccion       : byte address (sampled with inicio)
//   dato_escritura  : store data (sampled with inicio)
//   bus             : data-memory bus, master side
//   datoMem         : extended load result, updated only by successful loads
//   listo           : one-cycle completion pulse
//   ocupado         : high while an access is in progress or completing
//   error           : valid with listo; misaligned/illegal request or timeout
// -----------------------------------------------------------------------------
module unidad_acceso_memoria #(
  parameter int TIMEOUT_CICLOS = 16,
  parameter int ANCHO_CONT     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inicio,
  input  logic                     escritura,
  input  logic [2:0]               funct3,
  input  logic [31:0]              direccion,
  input  logic [31:0]              dato_escritura,
  unidad_acceso_memoria_if.master  bus,
  output logic [31:0]              datoMem,
  output logic                     listo,
  output logic                     ocupado,
  output logic                     error
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACCESO = 2'd1,
    FIN    = 2'd2
  } estado_t;

  localparam logic [ANCHO_CONT-1:0] CONT_MAX = ANCHO_CONT'(TIMEOUT_CICLOS - 1);

  // Legality of width code for the direction, plus natural alignment.
  function automatic logic solicitud_legal(input logic we, input logic [2:0] f3,
                                           input logic [1:0] k);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~k[0];
      3'b010:  ok = (k == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~k[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables: loads always read the full word.
  function automatic logic [3:0] calc_be(input logic we, input logic [2:0] f3,
                                         input logic [1:0] k);
    logic [3:0] be;
    if (!we) begin
      be = 4'b1111;
    end else begin
      case (f3)
        3'b000:  be = 4'b0001 << k;
        3'b001:  be = 4'b0011 << k;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replicating the store data puts it on every lane the enables may select.
  function automatic logic [31:0] calc_wdata(input logic we, input logic [2:0] f3,
                                             input logic [31:0] d);
    logic [31:0] w;
    if (!we) begin
      w = 32'h0000_0000;
    end else begin
      case (f3)
        3'b000:  w = {4{d[7:0]}};
        3'b001:  w = {2{d[15:0]}};
        default: w = d;
      endcase
    end
    return w;
  endfunction

  // Lane selection and extension of the read word.
  function automatic logic [31:0] extender_carga(input logic [2:0] f3,
                                                 input logic [1:0] k,
                                                 input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (k)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = k[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  estado_t                 estado_r, estado_s;
  logic [ANCHO_CONT-1:0]   cont_r, cont_s;
  logic                    es_escritura_r, es_escritura_s;
  logic [2:0]              f3_r, f3_s;
  logic [1:0]              desp_r, desp_s;
  logic                    req_r, req_s;
  logic                    we_r, we_s;
  logic [31:0]             addr_r, addr_s;
  logic [3:0]              be_r, be_s;
  logic [31:0]             wdata_r, wdata_s;
  logic [31:0]             dato_r, dato_s;
  logic                    listo_r, listo_s;
  logic                    error_r, error_s;
  logic                    ocupado_r, ocupado_s;
  logic                    valida_s;
  logic                    ack_s;
  logic                    timeout_s;

  assign valida_s  = solicitud_legal(escritura, funct3, direccion[1:0]);
  // An acknowledge only counts while a request is outstanding.
  assign ack_s     = bus.mem_ack & req_r;
  assign timeout_s = ~ack_s & (cont_r == CONT_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r <= REPOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      REPOSO: begin
        if (inicio) begin
          estado_s = valida_s ? ACCESO : FIN;
        end else begin
          estado_s = REPOSO;
        end
      end
      ACCESO: begin
        if (ack_s || timeout_s) begin
          estado_s = FIN;
        end else begin
          estado_s = ACCESO;
        end
      end
      FIN:     estado_s = REPOSO;
      default: estado_s = REPOSO;
    endcase
  end

  // Next values of the registered outputs and latched request fields.
  always_comb begin
    cont_s         = cont_r;
    es_escritura_s = es_escritura_r;
    f3_s           = f3_r;
    desp_s         = desp_r;
    req_s          = req_r;
    we_s           = we_r;
    addr_s         = addr_r;
    be_s           = be_r;
    wdata_s        = wdata_r;
    dato_s         = dato_r;
    listo_s        = 1'b0;
    error_s        = 1'b0;
    ocupado_s      = (estado_s != REPOSO);
    case (estado_r)
      REPOSO: begin
        cont_s = {ANCHO_CONT{1'b0}};
        if (inicio) begin
          es_escritura_s = escritura;
          f3_s           = funct3;
          desp_s         = direccion[1:0];
          if (valida_s) begin
            req_s   = 1'b1;
            we_s    = escritura;
            addr_s  = {direccion[31:2], 2'b00};
            be_s    = calc_be(escritura, funct3, direccion[1:0]);
            wdata_s = calc_wdata(escritura, funct3, dato_escritura);
          end else begin
            // Rejected before reaching the bus.
            listo_s = 1'b1;
            error_s = 1'b1;
          end
        end else begin
          req_s = 1'b0;
        end
      end
      ACCESO: begin
        if (ack_s) begin
          req_s   = 1'b0;
          we_s    = 1'b0;
          listo_s = 1'b1;
          error_s = 1'b0;
          if (!es_escritura_r) begin
            dato_s = extender_carga(f3_r, desp_r, bus.mem_rdata);
          end else begin
            dato_s = dato_r;
          end
        end else if (timeout_s) begin
          req_s   = 1'b0;
          we_s    = 1'b0;
          listo_s = 1'b1;
          error_s = 1'b1;
        end else begin
          cont_s = cont_r + 1'b1;
        end
      end
      FIN: begin
        cont_s = {ANCHO_CONT{1'b0}};
      end
      default: begin
        cont_s = {ANCHO_CONT{1'b0}};
        req_s  = 1'b0;
        we_s   = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_r         <= {ANCHO_CONT{1'b0}};
      es_escritura_r <= 1'b0;
      f3_r           <= 3'b000;
      desp_r         <= 2'b00;
      req_r          <= 1'b0;
      we_r           <= 1'b0;
      addr_r         <= 32'h0000_0000;
      be_r           <= 4'b0000;
      wdata_r        <= 32'h0000_0000;
      dato_r         <= 32'h0000_0000;
      listo_r        <= 1'b0;
      error_r        <= 1'b0;
      ocupado_r      <= 1'b0;
    end else begin
      cont_r         <= cont_s;
      es_escritura_r <= es_escritura_s;
      f3_r           <= f3_s;
      desp_r         <= desp_s;
      req_r          <= req_s;
      we_r           <= we_s;
      addr_r         <= addr_s;
      be_r           <= be_s;
      wdata_r        <= wdata_s;
      dato_r         <= dato_s;
      listo_r        <= listo_s;
      error_r        <= error_s;
      ocupado_r      <= ocupado_s;
    end
  end

  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_be    = be_r;
  assign bus.mem_wdata = wdata_r;
  assign datoMem       = dato_r;
  assign listo         = listo_r;
  assign error         = error_r;
  assign ocupado       = ocupado_r;

endmodule

// File: tb/tb_unidad_acceso_memoria.sv
// -----------------------------------------------------------------------------
// tb_unidad_acceso_memoria
// Self-checking bench: directed cases plus randomized loads/stores, compared
// against a reference model built from the RV32I load/store rules.
// -----------------------------------------------------------------------------
module tb_unidad_acceso_memoria;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic        escritura = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] direccion = 32'h0;
  logic [31:0] dato_escritura = 32'h0;
  logic [31:0] datoMem;
  logic        listo, ocupado, error;

  unidad_acceso_memoria_if bus();

  unidad_acceso_memoria #(.TIMEOUT_CICLOS(T), .ANCHO_CONT(5)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .escritura(escritura),
    .funct3(funct3), .direccion(direccion), .dato_escritura(dato_escritura),
    .bus(bus), .datoMem(datoMem), .listo(listo), .ocupado(ocupado), .error(error)
  );

  always #5 clk = ~clk;

  int n_pruebas = 0;
  int n_fallos  = 0;
  logic [31:0] modelo_dato = 32'h0;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_pruebas++;
    if (obs !== esp) begin
      n_fallos++;
      $display("FAIL %s: obtenido=0x%08h esperado=0x%08h", tag, obs, esp);
    end
  endtask

  // ---- reference model --------------------------------------------------
  function automatic bit ref_legal(input bit we, input int f3, input int k);
    if (we) return (f3 == 0) || (f3 == 1 && k % 2 == 0) || (f3 == 2 && k == 0);
    return (f3 == 0) || (f3 == 4) || ((f3 == 1 || f3 == 5) && k % 2 == 0) || (f3 == 2 && k == 0);
  endfunction

  function automatic logic [31:0] ref_carga(input int f3, input int k, input logic [31:0] rd);
    int v;
    int unsigned b, h;
    b = (rd >> (8 * k)) & 32'hFF;
    h = (rd >> (16 * (k / 2))) & 32'hFFFF;
    case (f3)
      0: begin v = int'(b); if (v >= 128) v = v - 256; return v; end
      1: begin v = int'(h); if (v >= 32768) v = v - 65536; return v; end
      4: return b;
      5: return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit we, input int f3, input int k);
    logic [3:0] uno, dos;
    uno = 4'b0001;
    dos = 4'b0011;
    if (!we) return 4'b1111;
    if (f3 == 0) return uno << k;
    if (f3 == 1) return dos << k;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
    if (f3 == 0) return d[7:0] * 32'h0101_0101;
    if (f3 == 1) return d[15:0] * 32'h0001_0001;
    return d;
  endfunction

  // One complete request. espera = ack after that many wait cycles (>=T: never).
  // intruso = pulse a second inicio during the access.
  task automatic acceso(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int espera, input logic [31:0] rd,
                        input bit intruso);
    bit legal, timeout, estable;
    int k, hi;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    k = int'(a[1:0]);
    legal = ref_legal(we, int'(f3), k);
    @(negedge clk);
    escritura = we; funct3 = f3; direccion = a; dato_escritura = d; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    if (!legal) begin
      comprobar("err_req", bus.mem_req, 1'b0);
      comprobar("err_listo", listo, 1'b1);
      comprobar("err_error", error, 1'b1);
      comprobar("err_dato", datoMem, modelo_dato);
    end else begin
      e_addr  = {a[31:2], 2'b00};
      e_be    = ref_be(we, int'(f3), k);
      e_wd    = ref_wdata(int'(f3), d);
      timeout = (espera >= T);
      hi = 0;
      estable = 1'b1;
      for (int n = 0; n < T + 4; n++) begin
        if (bus.mem_req !== 1'b1) break;
        hi++;
        if (bus.mem_addr !== e_addr || bus.mem_be !== e_be || bus.mem_we !== we ||
            (we && bus.mem_wdata !== e_wd) || listo !== 1'b0 || ocupado !== 1'b1)
          estable = 1'b0;
        if (intruso && n == 1) begin
          inicio = 1'b1; direccion = ~a; escritura = ~we;
        end
        if (!timeout && n == espera) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
        end
        @(negedge clk);
        inicio = 1'b0;
        bus.mem_ack = 1'b0;
      end
      comprobar("ciclos_req", hi, timeout ? T : espera + 1);
      comprobar("bus_estable", estable, 1'b1);
      comprobar("listo", listo, 1'b1);
      comprobar("error", error, timeout);
      if (!we && !timeout) modelo_dato = ref_carga(int'(f3), k, rd);
      comprobar("datoMem", datoMem, modelo_dato);
    end
    comprobar("ocupado_fin", ocupado, 1'b1);
    // A stray acknowledge while idle must be ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    comprobar("listo_pulso", listo, 1'b0);
    comprobar("ocupado_reposo", ocupado, 1'b0);
    comprobar("req_reposo", bus.mem_req, 1'b0);
    @(negedge clk);
    comprobar("sin_cola", bus.mem_req, 1'b0);
    comprobar("ack_ignorado", datoMem, modelo_dato);
    comprobar("listo_reposo", listo, 1'b0);
  endtask

  task automatic comprobar_reset(input string tag);
    comprobar({tag, "_req"},   bus.mem_req,   1'b0);
    comprobar({tag, "_we"},    bus.mem_we,    1'b0);
    comprobar({tag, "_addr"},  bus.mem_addr,  32'h0);
    comprobar({tag, "_be"},    bus.mem_be,    4'h0);
    comprobar({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    comprobar({tag, "_dato"},  datoMem,       32'h0);
    comprobar({tag, "_listo"}, listo,         1'b0);
    comprobar({tag, "_error"}, error,         1'b0);
    comprobar({tag, "_ocup"},  ocupado,       1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulacion sin terminar");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r, espera;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    comprobar_reset("reset");
    rst_n = 1'b1;

    // LB at 0x1003, immediate ack.
    acceso(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_7F01, 1'b0);
    comprobar("plan_lb", datoMem, 32'hFFFF_FF80);
    // LHU at 0x2002, three wait cycles, with an ignored second inicio.
    acceso(1'b0, 3'b101, 32'h0000_2002, 32'h0, 3, 32'hBEEF_1234, 1'b1);
    comprobar("plan_lhu", datoMem, 32'h0000_BEEF);
    // SB at 0x3001.
    acceso(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 1, $urandom, 1'b0);
    comprobar("plan_sb_dato", datoMem, 32'h0000_BEEF);
    // Misaligned LW and illegal funct3.
    acceso(1'b0, 3'b010, 32'h0000_4002, 32'h0, 0, 32'h0, 1'b0);
    acceso(1'b0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'h0, 1'b0);
    comprobar("plan_err_dato", datoMem, 32'h0000_BEEF);
    // Load that is never acknowledged.
    acceso(1'b0, 3'b010, 32'h0000_5000, 32'h0, T, 32'h0, 1'b0);

    // Reset in the middle of a store.
    @(negedge clk);
    escritura = 1'b1; funct3 = 3'b010; direccion = 32'h0000_6000;
    dato_escritura = 32'h1234_5678; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    comprobar("pre_reset_req", bus.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 comprobar_reset("reset_medio");
    modelo_dato = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    acceso(1'b0, 3'b001, 32'h0000_7002, 32'h0, 2, 32'h8001_7FFF, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      espera = (r == 9) ? T : (r % 5);
      acceso(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             espera, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
    $finish;
  end
endmodule

// File: doc/unidad_acceso_memoria.md
Name: unidad_acceso_memoria

Overview:
Load/store access unit between the execute stage and the data-memory bus. It converts one load or store request into a single word-aligned bus transaction with a request/acknowledge handshake, byte enables and a timeout. For loads it extracts and sign/zero-extends the addressed byte, halfword or word. The result drives datoMem into the write-back selector, which chooses between LUI immediate, adder result and memory data.

Parameters:
TIMEOUT_CICLOS, 16, max cycles mem_req stays high without mem_ack before the access aborts with error (>=2)
ANCHO_CONT, 5, width of timeout counter; must hold TIMEOUT_CICLOS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
inicio  input  1  start pulse from execute stage; accepted only in REPOSO
escritura  input  1  1 = store, 0 = load; sampled with inicio
funct3  input  3  RV32I width/sign code; sampled with inicio
direccion  input  32  byte address; sampled with inicio
dato_escritura  input  32  store data; sampled with inicio
mem_req  output  1  bus request, registered
mem_we  output  1  bus write strobe, registered
mem_addr  output  32  word address {direccion[31:2],2'b00}, registered
mem_be  output  4  byte enables, registered
mem_wdata  output  32  lane-aligned store data, registered
mem_ack  input  1  bus acknowledge; rdata valid in same cycle for loads
mem_rdata  input  32  bus read data
datoMem  output  32  extended load result to write-back selector, registered
listo  output  1  one-cycle completion pulse
ocupado  output  1  high in ACCESO and FIN
error  output  1  valid with listo; misalignment, illegal funct3 or timeout

Behaviour:
- Reset (async, rst_n=0): state REPOSO; mem_req, mem_we, listo, error = 0; mem_addr, mem_be, mem_wdata, datoMem = 0; counter = 0. Reset mid-access drops mem_req immediately. No retry after release.
- States: REPOSO, ACCESO, FIN.
- REPOSO: ocupado=0. If inicio=1, latch escritura, funct3, direccion and dato_escritura, then check the request:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Halfword needs direccion[0]=0. Word needs direccion[1:0]=00.
  - Illegal or misaligned: go to FIN with error=1; mem_req never asserts.
  - Otherwise: go to ACCESO with mem_req=1 from the next cycle.
- ACCESO: mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until exit. The counter increments each cycle mem_ack=0.
  - mem_ack=1 at a rising edge: clear mem_req, go to FIN, error=0. For loads, capture the extended rdata into datoMem at that edge.
  - Counter reaches TIMEOUT_CICLOS-1 with no ack: clear mem_req, go to FIN, error=1; datoMem unchanged.
- FIN: listo=1 for exactly one cycle, error valid, then REPOSO. The counter clears.
- inicio while ocupado=1 is ignored, not queued. mem_ack while mem_req=0 is ignored.
- Store lanes, with k=direccion[1:0]:
  - SB: mem_be = 0001<<k; mem_wdata = byte replicated x4.
  - SH: mem_be = 0011<<k; mem_wdata = halfword replicated x2.
  - SW: mem_be = 1111; mem_wdata = data as-is.
- Load lanes: LB/LBU select mem_rdata byte k; LH/LHU select halfword k[1]; extend per funct3.
- Loads use mem_be=1111 and mem_we=0.
- datoMem changes only on a successful load; stores and errors leave it unchanged.
- Latency: inicio at edge t0, mem_req high from t0, ack sampled at edge t1, listo high in cycle t1..t2. Minimum 2 cycles inicio-to-listo; error path is 1 cycle.

Test Plan:
- LB with direccion=0x1003, mem_rdata=0x80FF_7F01, ack on first cycle -> mem_addr=0x1000, mem_be=1111, datoMem=0xFFFF_FF80, listo pulses once, error=0.
- LHU at 0x2002, rdata=0xBEEF_1234, ack after 3 wait cycles -> mem_req held 4 cycles with stable address, datoMem=0x0000_BEEF.
- SB at 0x3001, dato_escritura=0x0000_00A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5; datoMem unchanged.
- LW at 0x4002 -> no mem_req, listo+error=1 the cycle after inicio. Repeat with funct3=011 -> same.
- Load with ack never asserted, TIMEOUT_CICLOS=16 -> mem_req high exactly 16 cycles, then listo+error=1.
- Second inicio during ACCESO, then rst_n low mid-access -> second request ignored; reset drops mem_req asynchronously, all outputs 0, next inicio serviced normally.
